execute_branch_redirect: RTL and testbench

Parametrised branch-completion and redirect stage of the MIST1032SA execute unit. It accepts resolved branch-class operations from the branch issue path and reports every accepted commit tag to the schedulers through a DEPTH-entry completion FIFO with back-pressure. Redirect-class operations (taken jump, interrupt return, IDTS, SWI) are presented to fetch/exception control as one registered redirect that is held until acknowledged. The block then locks until the pipeline free-restart.

---
 rtl/execute_branch_redirect.sv | 120 ++++++++++++
 tb/tb_execute_branch_redirect.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_branch_redirect.sv
// Branch-completion and redirect stage: reports accepted commit tags through a
// completion FIFO and holds one redirect until acknowledged, then locks until restart.
module execute_branch_redirect #(
  parameter int unsigned TAG_W = 6,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SWI_W = 11
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iFREE_RESTART,
  input  logic             iPREV_VALID,
  input  logic [1:0]       iPREV_KIND,
  input  logic             iPREV_TAKEN,
  input  logic [TAG_W-1:0] iPREV_TAG,
  input  logic [PC_W-1:0]  iPREV_ADDR,
  output logic             oPREV_LOCK,
  output logic             oRD_VALID,
  output logic [1:0]       oRD_KIND,
  output logic [PC_W-1:0]  oRD_ADDR,
  output logic [TAG_W-1:0] oRD_TAG,
  input  logic             iRD_ACK,
  output logic             oSCHE_VALID,
  output logic [TAG_W-1:0] oSCHE_TAG,
  input  logic             iSCHE_READY
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       rd_kind_q;
  logic [PC_W-1:0]  rd_addr_q;
  logic [TAG_W-1:0] rd_tag_q;

  logic             accept, pop, redirect_cls;
  logic [PC_W-1:0]  addr_cap;

  // Lock depends on registers only, so there is no input-to-lock path.
  assign oPREV_LOCK   = (state_q != ST_IDLE) || (count_q == FULL);
  assign accept       = iPREV_VALID && !oPREV_LOCK;
  assign oSCHE_VALID  = (count_q != '0);
  assign pop          = oSCHE_VALID && iSCHE_READY;
  assign redirect_cls = (iPREV_KIND != 2'd0) || iPREV_TAKEN;

  assign oSCHE_TAG = oSCHE_VALID ? mem_q[rd_ptr_q] : '0;
  assign oRD_VALID = (state_q == ST_REDIRECT);
  assign oRD_KIND  = rd_kind_q;
  assign oRD_ADDR  = rd_addr_q;
  assign oRD_TAG   = rd_tag_q;

  always_comb begin
    addr_cap = iPREV_ADDR;
    if (iPREV_KIND == 2'd3) begin
      addr_cap = '0;
      addr_cap[SWI_W-1:0] = iPREV_ADDR[SWI_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept && redirect_cls) state_d = ST_REDIRECT;
      ST_REDIRECT: if (iRD_ACK) state_d = ST_LOCKED;
      ST_LOCKED:   state_d = ST_LOCKED;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_kind_q <= '0;
      rd_addr_q <= '0;
      rd_tag_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (iFREE_RESTART) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_kind_q <= '0;
      rd_addr_q <= '0;
      rd_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        mem_q[wr_ptr_q] <= iPREV_TAG;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (accept && redirect_cls) begin
        rd_kind_q <= iPREV_KIND;
        rd_addr_q <= addr_cap;
        rd_tag_q  <= iPREV_TAG;
      end
    end
  end

endmodule

// File: tb/tb_execute_branch_redirect.sv
// Scoreboard bench for execute_branch_redirect: stimulus pushes expected tags and
// redirects into queues; a negedge monitor pops and compares what the DUT presents.
module tb_execute_branch_redirect;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iFREE_RESTART = 1'b0;
  logic        iPREV_VALID = 1'b0;
  logic [1:0]  iPREV_KIND = '0;
  logic        iPREV_TAKEN = 1'b0;
  logic [5:0]  iPREV_TAG = '0;
  logic [31:0] iPREV_ADDR = '0;
  logic        oPREV_LOCK;
  logic        oRD_VALID;
  logic [1:0]  oRD_KIND;
  logic [31:0] oRD_ADDR;
  logic [5:0]  oRD_TAG;
  logic        iRD_ACK = 1'b0;
  logic        oSCHE_VALID;
  logic [5:0]  oSCHE_TAG;
  logic        iSCHE_READY = 1'b0;

  execute_branch_redirect #(
    .TAG_W(6), .PC_W(32), .DEPTH(4), .SWI_W(11)
  ) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFREE_RESTART(iFREE_RESTART),
    .iPREV_VALID(iPREV_VALID), .iPREV_KIND(iPREV_KIND), .iPREV_TAKEN(iPREV_TAKEN),
    .iPREV_TAG(iPREV_TAG), .iPREV_ADDR(iPREV_ADDR), .oPREV_LOCK(oPREV_LOCK),
    .oRD_VALID(oRD_VALID), .oRD_KIND(oRD_KIND), .oRD_ADDR(oRD_ADDR), .oRD_TAG(oRD_TAG),
    .iRD_ACK(iRD_ACK), .oSCHE_VALID(oSCHE_VALID), .oSCHE_TAG(oSCHE_TAG),
    .iSCHE_READY(iSCHE_READY)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [5:0]  tag;
  } rd_t;

  logic [5:0] sche_q[$];
  rd_t        rd_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       rd_prev = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: completion pops and the first cycle of each redirect.
  always @(negedge iCLOCK) begin
    if (inRESET && oSCHE_VALID && iSCHE_READY) begin
      if (sche_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sche_unexpected: got tag %0h expected none", oSCHE_TAG);
      end else begin
        chk("sche_tag", oSCHE_TAG, sche_q.pop_front());
      end
    end
    if (inRESET && oRD_VALID && !rd_prev) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_unexpected: got tag %0h expected none", oRD_TAG);
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        chk("rd_kind", oRD_KIND, e.kind);
        chk("rd_addr", oRD_ADDR, e.addr);
        chk("rd_tag", oRD_TAG, e.tag);
      end
    end
    rd_prev = oRD_VALID;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge iCLOCK); #1;
  endtask

  task automatic offer(input logic [1:0] k, input logic t, input logic [5:0] tg,
                       input logic [31:0] a, input logic [31:0] exp_a,
                       input int maxc, output bit ok);
    logic lk;
    ok = 1'b0;
    iPREV_VALID = 1'b1; iPREV_KIND = k; iPREV_TAKEN = t;
    iPREV_TAG = tg; iPREV_ADDR = a;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge iCLOCK); lk = oPREV_LOCK;
      @(posedge iCLOCK); #1;
      if (!lk) begin
        ok = 1'b1;
        sche_q.push_back(tg);
        if (k != 2'd0 || t) rd_q.push_back('{k, exp_a, tg});
      end
    end
    iPREV_VALID = 1'b0;
  endtask

  task automatic restart(input logic ack);
    iFREE_RESTART = 1'b1; iRD_ACK = ack;
    sync();
    iFREE_RESTART = 1'b0; iRD_ACK = 1'b0;
    sche_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lock"}, oPREV_LOCK, 0);
    chk({tag, "_rd_valid"}, oRD_VALID, 0);
    chk({tag, "_rd_kind"}, oRD_KIND, 0);
    chk({tag, "_rd_addr"}, oRD_ADDR, 0);
    chk({tag, "_rd_tag"}, oRD_TAG, 0);
    chk({tag, "_sche_valid"}, oSCHE_VALID, 0);
    chk({tag, "_sche_tag"}, oSCHE_TAG, 0);
  endtask

  initial begin
    bit ok;
    @(negedge iCLOCK);
    check_reset_vals("reset");
    sync();
    inRESET = 1'b1;

    // Four not-taken jumps, drained one per cycle.
    iSCHE_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(2'd0, 1'b0, 6'(i), 32'h0, 32'h0, 1, ok);
      chk("nt_accept", ok, 1);
    end
    sync();
    @(negedge iCLOCK);
    chk("nt_rd_valid", oRD_VALID, 0);
    chk("nt_drained", oSCHE_VALID, 0);
    chk("nt_queue", sche_q.size(), 0);

    // Fill to DEPTH with scheduler stalled.
    sync();
    iSCHE_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(2'd0, 1'b0, 6'(i), 32'h0, 32'h0, 1, ok);
      chk("fill_accept", ok, 1);
    end
    @(negedge iCLOCK);
    chk("full_lock", oPREV_LOCK, 1);
    chk("full_head", oSCHE_TAG, 6'h0);
    sync();
    iSCHE_READY = 1'b1;
    sync();
    iSCHE_READY = 1'b0;
    @(negedge iCLOCK);
    chk("pop_unlock", oPREV_LOCK, 0);
    sync();
    offer(2'd0, 1'b0, 6'd4, 32'h0, 32'h0, 1, ok);
    chk("tag4_accept", ok, 1);
    offer(2'd0, 1'b0, 6'd5, 32'h0, 32'h0, 3, ok);
    chk("tag5_refused", ok, 0);
    iSCHE_READY = 1'b1;
    repeat (6) sync();
    chk("fill_drained", sche_q.size(), 0);

    // Taken jump held without ack, then acked.
    offer(2'd0, 1'b1, 6'h2A, 32'h0000_1000, 32'h0000_1000, 1, ok);
    chk("jmp_accept", ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLOCK);
      chk("jmp_hold_valid", oRD_VALID, 1);
      chk("jmp_hold_kind", oRD_KIND, 0);
      chk("jmp_hold_addr", oRD_ADDR, 32'h0000_1000);
      chk("jmp_hold_tag", oRD_TAG, 6'h2A);
      chk("jmp_hold_lock", oPREV_LOCK, 1);
      sync();
    end
    iRD_ACK = 1'b1;
    sync();
    iRD_ACK = 1'b0;
    @(negedge iCLOCK);
    chk("ack_rd_valid", oRD_VALID, 0);
    chk("ack_lock", oPREV_LOCK, 1);
    sync();
    restart(1'b0);
    @(negedge iCLOCK);
    check_reset_vals("restart1");

    // SWI number is zero-extended.
    sync();
    offer(2'd3, 1'b0, 6'd7, 32'hFFFF_F7FF, 32'h0000_07FF, 1, ok);
    chk("swi_accept", ok, 1);
    @(negedge iCLOCK);
    chk("swi_kind", oRD_KIND, 2'd3);
    chk("swi_addr", oRD_ADDR, 32'h0000_07FF);
    sync();
    iRD_ACK = 1'b1;
    sync();
    iRD_ACK = 1'b0;
    restart(1'b0);

    // Restart in REDIRECT with three entries and a simultaneous ack.
    iSCHE_READY = 1'b0;
    offer(2'd0, 1'b0, 6'h11, 32'h0, 32'h0, 1, ok);
    chk("r3_accept_a", ok, 1);
    offer(2'd0, 1'b0, 6'h12, 32'h0, 32'h0, 1, ok);
    chk("r3_accept_b", ok, 1);
    offer(2'd0, 1'b1, 6'h13, 32'h0000_2000, 32'h0000_2000, 1, ok);
    chk("r3_accept_c", ok, 1);
    @(negedge iCLOCK);
    chk("r3_rd_valid", oRD_VALID, 1);
    chk("r3_head", oSCHE_TAG, 6'h11);
    sync();
    restart(1'b1);
    @(negedge iCLOCK);
    check_reset_vals("restart2");
    sync();
    offer(2'd0, 1'b0, 6'h14, 32'h0, 32'h0, 1, ok);
    chk("post_restart_accept", ok, 1);
    @(negedge iCLOCK);
    chk("post_restart_head", oSCHE_TAG, 6'h14);
    sync();
    iSCHE_READY = 1'b1;
    repeat (3) sync();

    // Asynchronous reset while LOCKED.
    offer(2'd0, 1'b1, 6'h05, 32'h0000_3000, 32'h0000_3000, 1, ok);
    chk("lk_accept", ok, 1);
    sync();
    iRD_ACK = 1'b1;
    sync();
    iRD_ACK = 1'b0;
    @(negedge iCLOCK);
    chk("lk_locked", oPREV_LOCK, 1);
    chk("lk_rd_valid", oRD_VALID, 0);
    sync();
    #3 inRESET = 1'b0;
    #1 check_reset_vals("async");
    sche_q.delete();
    sync();
    inRESET = 1'b1;
    @(negedge iCLOCK);
    chk("async_release_lock", oPREV_LOCK, 0);

    chk("end_sche_queue", sche_q.size(), 0);
    chk("end_rd_queue", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
